// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control-bus bit layout and ID/EX FSM states.
package pipeline_pkg;

  localparam int CTRL_W     = 9;
  localparam int REG_WRITE  = 0;
  localparam int MEM_TO_REG = 1;
  localparam int MEM_READ   = 2;
  localparam int MEM_WRITE  = 3;
  localparam int ALU_SRC    = 4;
  localparam int REG_DST    = 5;
  localparam int ALU_OP_LSB = 6;
  localparam int ALU_OP_MSB = 8;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the load in EX and the instruction in ID.
module hazard_detect #(
  parameter int W = 5
) (
  input  logic         i_valid_ex,
  input  logic         i_mem_read_ex,
  input  logic [W-1:0] i_rt_ex,
  input  logic         i_valid_id,
  input  logic         i_alu_src_id,
  input  logic         i_mem_write_id,
  input  logic [W-1:0] i_rs_id,
  input  logic [W-1:0] i_rt_id,
  output logic         o_haz
);

  logic uses_rt;
  logic rs_hit;
  logic rt_hit;

  always_comb begin
    uses_rt = !i_alu_src_id | i_mem_write_id;
    rs_hit  = (i_rt_ex == i_rs_id);
    rt_hit  = (i_rt_ex == i_rt_id) & uses_rt;
    // $0 is hardwired, so a load to it can never be consumed
    o_haz   = i_valid_ex & i_mem_read_ex
            & (i_rt_ex != '0) & i_valid_id
            & (rs_hit | rt_hit);
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use stall, flush and halt drain.
// Optional perf counters: define ID_EX_PERF_CNT_EN.
module id_ex_stage_reg
  import pipeline_pkg::*;
#(
  parameter int B      = 32,
  parameter int W      = 5,
  parameter int CTRL_W = 9
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid_ID,
  input  logic              i_halt_ID,
  input  logic [CTRL_W-1:0] i_ctrl_ID,
  input  logic [B-1:0]      i_read_data_1,
  input  logic [B-1:0]      i_read_data_2,
  input  logic [B-1:0]      i_imm_ID,
  input  logic [W-1:0]      i_rs_ID,
  input  logic [W-1:0]      i_rt_ID,
  input  logic [W-1:0]      i_rd_ID,
  input  logic              i_flush,
  output logic              o_stall,
  output logic              o_valid_EX,
  output logic [CTRL_W-1:0] o_ctrl_EX,
  output logic [B-1:0]      o_read_data_1_EX,
  output logic [B-1:0]      o_read_data_2_EX,
  output logic [B-1:0]      o_imm_EX,
  output logic [W-1:0]      o_rs_EX,
  output logic [W-1:0]      o_rt_EX,
  output logic [W-1:0]      o_rd_EX,
  output logic              o_halted
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]       o_stall_cnt,
  output logic [31:0]       o_flush_cnt
`endif
);

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [B-1:0]      rd1_q, rd1_d;
  logic [B-1:0]      rd2_q, rd2_d;
  logic [B-1:0]      imm_q, imm_d;
  logic [W-1:0]      rs_q, rs_d;
  logic [W-1:0]      rt_q, rt_d;
  logic [W-1:0]      rd_q, rd_d;
  logic              haz;
  logic              stall;
  logic              bubble;

  hazard_detect #(.W(W)) u_haz (
    .i_valid_ex     (valid_q),
    .i_mem_read_ex  (ctrl_q[MEM_READ]),
    .i_rt_ex        (rt_q),
    .i_valid_id     (i_valid_ID),
    .i_alu_src_id   (i_ctrl_ID[ALU_SRC]),
    .i_mem_write_id (i_ctrl_ID[MEM_WRITE]),
    .i_rs_id        (i_rs_ID),
    .i_rt_id        (i_rt_ID),
    .o_haz          (haz)
  );

  always_comb begin
    stall   = ((state_q == RUN) & haz & !i_flush)
            | (state_q == HALTED);
    // anything outside RUN is killed on its way into EX
    bubble  = stall | i_flush | (state_q != RUN);
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = i_valid_ID & !bubble;
    ctrl_d  = bubble ? '0 : i_ctrl_ID;
    rd1_d   = i_read_data_1;
    rd2_d   = i_read_data_2;
    imm_d   = i_imm_ID;
    rs_d    = i_rs_ID;
    rt_d    = i_rt_ID;
    rd_d    = i_rd_ID;
    unique case (1'b1)
      (state_q == RUN): begin
        if (!bubble & i_valid_ID & i_halt_ID) begin
          state_d = DRAIN;
          cnt_d   = 2'd0;
        end
      end
      (state_q == DRAIN): begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd2) state_d = HALTED;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall & (state_q == RUN))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (i_flush)
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`endif

  assign o_stall          = stall;
  assign o_valid_EX       = valid_q;
  assign o_ctrl_EX        = ctrl_q;
  assign o_read_data_1_EX = rd1_q;
  assign o_read_data_2_EX = rd2_q;
  assign o_imm_EX         = imm_q;
  assign o_rs_EX          = rs_q;
  assign o_rt_EX          = rt_q;
  assign o_rd_EX          = rd_q;
  assign o_halted         = (state_q == HALTED);

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: load, hazard, flush, halt, reset.
module tb_id_ex_stage_reg;

  localparam int B = 32;
  localparam int W = 5;
  localparam int CW = 9;

  localparam logic [CW-1:0] C_ADD  = 9'h0A1;
  localparam logic [CW-1:0] C_LW   = 9'h017;
  localparam logic [CW-1:0] C_ADDI = 9'h011;
  localparam logic [CW-1:0] C_SW   = 9'h018;

  logic          clk;
  logic          reset;
  logic          valid_id;
  logic          halt_id;
  logic [CW-1:0] ctrl_id;
  logic [B-1:0]  rd1_id, rd2_id, imm_id;
  logic [W-1:0]  rs_id, rt_id, rd_id;
  logic          flush;
  logic          stall;
  logic          valid_ex;
  logic [CW-1:0] ctrl_ex;
  logic [B-1:0]  rd1_ex, rd2_ex, imm_ex;
  logic [W-1:0]  rs_ex, rt_ex, rd_ex;
  logic          halted;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0]   stall_cnt, flush_cnt;
  logic [31:0]   sc0, fc0;
`endif

  int pass;
  int total;

  id_ex_stage_reg #(.B(B), .W(W), .CTRL_W(CW)) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_valid_ID       (valid_id),
    .i_halt_ID        (halt_id),
    .i_ctrl_ID        (ctrl_id),
    .i_read_data_1    (rd1_id),
    .i_read_data_2    (rd2_id),
    .i_imm_ID         (imm_id),
    .i_rs_ID          (rs_id),
    .i_rt_ID          (rt_id),
    .i_rd_ID          (rd_id),
    .i_flush          (flush),
    .o_stall          (stall),
    .o_valid_EX       (valid_ex),
    .o_ctrl_EX        (ctrl_ex),
    .o_read_data_1_EX (rd1_ex),
    .o_read_data_2_EX (rd2_ex),
    .o_imm_EX         (imm_ex),
    .o_rs_EX          (rs_ex),
    .o_rt_EX          (rt_ex),
    .o_rd_EX          (rd_ex),
    .o_halted         (halted)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .o_stall_cnt      (stall_cnt),
    .o_flush_cnt      (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic h,
                       input logic [CW-1:0] c,
                       input logic [B-1:0] a, input logic [B-1:0] b,
                       input logic [B-1:0] im,
                       input logic [W-1:0] s, input logic [W-1:0] t,
                       input logic [W-1:0] d);
    valid_id = v; halt_id = h; ctrl_id = c;
    rd1_id = a; rd2_id = b; imm_id = im;
    rs_id = s; rt_id = t; rd_id = d;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, C_LW, 32'hAA, 32'hBB, 32'hCC, 1, 4, 6);
    reset = 1'b1;
    step();
    step();
    total++;
    if ({valid_ex, ctrl_ex, rd1_ex, rd2_ex, imm_ex,
         rs_ex, rt_ex, rd_ex} !== '0)
      $display("FAIL reset_outs valid=%b ctrl=%h rd1=%h rt=%0d want all 0",
               valid_ex, ctrl_ex, rd1_ex, rt_ex);
    else pass++;
    total++;
    if ({stall, halted} !== 2'b00)
      $display("FAIL reset_flags stall=%b halted=%b want 0 0", stall, halted);
    else pass++;
`ifdef ID_EX_PERF_CNT_EN
    total++;
    if ({stall_cnt, flush_cnt} !== 64'd0)
      $display("FAIL reset_cnt s=%0d f=%0d want 0 0", stall_cnt, flush_cnt);
    else pass++;
`endif
    reset = 1'b0;
    drive(0, 0, '0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_normal();
    drive(1, 0, C_ADD, 5, 7, 0, 1, 2, 3);
    total++;
    if (stall !== 1'b0)
      $display("FAIL add_nostall stall=%b want 0", stall);
    else pass++;
    step();
    total++;
    if ({valid_ex, ctrl_ex, rd1_ex, rd2_ex, rd_ex} !==
        {1'b1, C_ADD, 32'd5, 32'd7, 5'd3})
      $display("FAIL add_load v=%b c=%h a=%0d b=%0d rd=%0d want 1 0a1 5 7 3",
               valid_ex, ctrl_ex, rd1_ex, rd2_ex, rd_ex);
    else pass++;
  endtask

  task automatic test_load_use();
    drive(1, 0, C_LW, 0, 0, 8, 1, 4, 0);
    step();
`ifdef ID_EX_PERF_CNT_EN
    sc0 = stall_cnt;
`endif
    drive(1, 0, C_ADD, 11, 12, 0, 4, 2, 5);
    total++;
    if (stall !== 1'b1)
      $display("FAIL lu_stall stall=%b want 1", stall);
    else pass++;
    step();
    total++;
    if ({valid_ex, ctrl_ex, stall} !== {1'b0, {CW{1'b0}}, 1'b0})
      $display("FAIL lu_bubble v=%b c=%h stall=%b want 0 000 0",
               valid_ex, ctrl_ex, stall);
    else pass++;
`ifdef ID_EX_PERF_CNT_EN
    total++;
    if (stall_cnt !== sc0 + 32'd1)
      $display("FAIL lu_stall_cnt got %0d want %0d", stall_cnt, sc0 + 1);
    else pass++;
`endif
    step();
    total++;
    if ({valid_ex, ctrl_ex, rs_ex, rd_ex, rd1_ex} !==
        {1'b1, C_ADD, 5'd4, 5'd5, 32'd11})
      $display("FAIL lu_release v=%b c=%h rs=%0d rd=%0d a=%0d want 1 0a1 4 5 11",
               valid_ex, ctrl_ex, rs_ex, rd_ex, rd1_ex);
    else pass++;
    drive(1, 0, C_LW, 0, 0, 8, 1, 0, 0);
    step();
    drive(1, 0, C_ADD, 1, 2, 0, 0, 0, 7);
    total++;
    if (stall !== 1'b0)
      $display("FAIL lu_r0 stall=%b want 0", stall);
    else pass++;
    step();
    total++;
    if ({valid_ex, rd_ex} !== {1'b1, 5'd7})
      $display("FAIL lu_r0_load v=%b rd=%0d want 1 7", valid_ex, rd_ex);
    else pass++;
  endtask

  task automatic test_rt_use();
    drive(1, 0, C_LW, 0, 0, 8, 1, 4, 0);
    step();
    drive(1, 0, C_ADDI, 0, 0, 3, 2, 4, 0);
    total++;
    if (stall !== 1'b0)
      $display("FAIL addi_rt stall=%b want 0", stall);
    else pass++;
    drive(1, 0, C_SW, 0, 0, 3, 2, 4, 0);
    total++;
    if (stall !== 1'b1)
      $display("FAIL sw_rt stall=%b want 1", stall);
    else pass++;
    drive(0, 0, C_ADD, 0, 0, 0, 4, 4, 0);
    total++;
    if (stall !== 1'b0)
      $display("FAIL id_invalid stall=%b want 0", stall);
    else pass++;
    step();
  endtask

  task automatic test_flush();
    drive(1, 0, C_LW, 0, 0, 8, 1, 4, 0);
    step();
`ifdef ID_EX_PERF_CNT_EN
    sc0 = stall_cnt;
    fc0 = flush_cnt;
`endif
    drive(1, 0, C_ADD, 1, 2, 0, 4, 2, 9);
    flush = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0)
      $display("FAIL flush_haz stall=%b want 0", stall);
    else pass++;
    step();
    flush = 1'b0;
    #1;
    total++;
    if ({valid_ex, ctrl_ex} !== {1'b0, {CW{1'b0}}})
      $display("FAIL flush_bubble v=%b c=%h want 0 000", valid_ex, ctrl_ex);
    else pass++;
`ifdef ID_EX_PERF_CNT_EN
    total++;
    if ({flush_cnt, stall_cnt} !== {fc0 + 32'd1, sc0})
      $display("FAIL flush_cnt f=%0d s=%0d want %0d %0d",
               flush_cnt, stall_cnt, fc0 + 1, sc0);
    else pass++;
`endif
    step();
  endtask

  task automatic test_halt();
    drive(1, 1, '0, 0, 0, 0, 0, 0, 0);
    step();
    total++;
    if ({valid_ex, halted, stall} !== 3'b100)
      $display("FAIL halt_ex v=%b h=%b s=%b want 1 0 0", valid_ex, halted, stall);
    else pass++;
    drive(1, 0, C_ADD, 1, 2, 0, 1, 2, 3);
    for (int i = 1; i <= 2; i++) begin
      step();
      total++;
      if ({valid_ex, ctrl_ex, halted, stall} !== {1'b0, {CW{1'b0}}, 2'b00})
        $display("FAIL drain_%0d v=%b c=%h h=%b s=%b want 0 000 0 0",
                 i, valid_ex, ctrl_ex, halted, stall);
      else pass++;
    end
    for (int i = 3; i <= 5; i++) begin
      step();
      total++;
      if ({valid_ex, ctrl_ex, halted, stall} !== {1'b0, {CW{1'b0}}, 2'b11})
        $display("FAIL halted_%0d v=%b c=%h h=%b s=%b want 0 000 1 1",
                 i, valid_ex, ctrl_ex, halted, stall);
      else pass++;
    end
  endtask

  task automatic test_reset_mid_drain();
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1, 1, '0, 0, 0, 0, 0, 0, 0);
    step();
    drive(1, 0, C_ADD, 1, 2, 0, 1, 2, 3);
    step();
    reset = 1'b1;
    step();
    step();
    total++;
    if ({valid_ex, ctrl_ex, rd_ex, halted, stall} !== '0)
      $display("FAIL rst_drain v=%b c=%h rd=%0d h=%b s=%b want all 0",
               valid_ex, ctrl_ex, rd_ex, halted, stall);
    else pass++;
    reset = 1'b0;
    drive(1, 0, C_ADD, 21, 22, 0, 1, 2, 8);
    step();
    total++;
    if ({valid_ex, ctrl_ex, rd_ex, halted} !== {1'b1, C_ADD, 5'd8, 1'b0})
      $display("FAIL rst_run v=%b c=%h rd=%0d h=%b want 1 0a1 8 0",
               valid_ex, ctrl_ex, rd_ex, halted);
    else pass++;
    step();
    total++;
    if ({valid_ex, halted, stall} !== 3'b100)
      $display("FAIL rst_run2 v=%b h=%b s=%b want 1 0 0",
               valid_ex, halted, stall);
    else pass++;
  endtask

  initial begin
    pass = 0;
    total = 0;
    reset = 1'b1;
    flush = 1'b0;
    valid_id = 1'b0; halt_id = 1'b0; ctrl_id = '0;
    rd1_id = '0; rd2_id = '0; imm_id = '0;
    rs_id = '0; rt_id = '0; rd_id = '0;
    #2;
    test_reset();
    test_normal();
    test_load_use();
    test_rt_use();
    test_flush();
    test_halt();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Pipeline register between the ID stage (register file, sign extend, control unit) and the EX stage.
- Captures read data 1/2, the immediate, register specifiers and the packed control bus on each rising clock edge.
- Contains load-use hazard detection: stalls PC/IF-ID and inserts one bubble into EX.
- Honours branch/jump flush and a halt drain, so the rest of the pipeline sees a clean valid/control stream.

Parameters:
- B, 32, data width of operands and immediate
- W, 5, register-specifier width
- CTRL_W, 9, packed control-bus width (field layout in package)

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_valid_ID  in  1  ID holds a real instruction
- i_halt_ID  in  1  ID instruction is HALT
- i_ctrl_ID  in  CTRL_W  packed control from control unit
- i_read_data_1  in  B  register-file read data 1
- i_read_data_2  in  B  register-file read data 2
- i_imm_ID  in  B  sign-extended immediate
- i_rs_ID  in  W  rs specifier
- i_rt_ID  in  W  rt specifier
- i_rd_ID  in  W  rd specifier
- i_flush  in  1  branch/jump taken in EX: kill the ID instruction
- o_stall  out  1  freeze PC and IF/ID this cycle
- o_valid_EX  out  1  EX holds a real instruction
- o_ctrl_EX  out  CTRL_W  registered control
- o_read_data_1_EX  out  B  registered operand 1
- o_read_data_2_EX  out  B  registered operand 2
- o_imm_EX  out  B  registered immediate
- o_rs_EX  out  W  registered rs
- o_rt_EX  out  W  registered rt
- o_rd_EX  out  W  registered rd
- o_halted  out  1  HALT has left EX; pipeline drained

Behaviour:
- Reset: all registered outputs 0, state RUN, o_stall 0, o_halted 0. Reset mid-stall or mid-halt returns to RUN next edge.
- Latency: one cycle, ID inputs at edge N appear on outputs after edge N.
- Hazard (combinational):
  - haz = o_valid_EX & ctrl_EX.mem_read & (o_rt_EX != 0) & i_valid_ID & ((o_rt_EX == i_rs_ID) | (o_rt_EX == i_rt_ID & uses_rt(i_ctrl_ID))).
  - uses_rt = !alu_src | mem_write.
- o_stall = (state == RUN) & haz & !i_flush; o_stall = 1 whenever state == HALTED.
- Bubble rule: on o_stall or i_flush, the next edge loads valid = 0 and ctrl = 0. Data fields load anyway (don't-care).
- Priority: i_reset > i_flush > haz stall > normal load. Flush with a simultaneous hazard gives a bubble with no stall.
- FSM states:
  - RUN: normal operation.
  - DRAIN: entered when a valid, non-flushed HALT is loaded into EX. Further ID inputs are bubbled; o_stall 0, so upstream keeps fetching (fetched instructions are killed). Move to HALTED after 3 cycles (EX→MEM→WB drain), counted by a 2-bit counter.
  - HALTED: o_halted 1, o_stall 1, outputs hold bubble. Exit only by reset.
- A stall lasts exactly one cycle per hazard. The re-evaluated hazard is false because EX then holds the bubble.
- Register $0 never causes a hazard.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- With it: adds outputs o_stall_cnt[31:0] and o_flush_cnt[31:0], incremented on cycles with o_stall=1 & state==RUN and with i_flush=1 respectively. Both wrap at 2^32, clear on reset.
- Without it: ports and logic absent; all other behaviour identical.

Decomposition:
- Package pipeline_pkg holds:
  - CTRL_W
  - control bit indices: REG_WRITE 0, MEM_TO_REG 1, MEM_READ 2, MEM_WRITE 3, ALU_SRC 4, REG_DST 5, ALU_OP 8:6
  - FSM state typedef (RUN, DRAIN, HALTED)
- One sub-module: hazard_detect, purely combinational, computing haz from the EX and ID fields.

Test Plan:
- Reset asserted 2 cycles mid-DRAIN -> all outputs 0, o_halted 0, state RUN on the next cycle.
- Sequence ADD r3,r1,r2 with r1=5, r2=7, then valid ADD -> after one edge o_read_data_1_EX=5, o_read_data_2_EX=7, o_rd_EX=3, o_valid_EX=1; no stall.
- Load-use hazard: EX holds LW (mem_read=1) to rt=4; ID presents ADD with rs=4 -> o_stall=1 for exactly 1 cycle, then o_valid_EX=0 and ctrl=0 (bubble); the next edge loads the ADD. Same case with rt=0 -> no stall.
- LW rt=4 in EX while ID holds ADDI rt=4 (alu_src=1, rs=2) -> no stall.
- i_flush=1 together with a load-use hazard -> o_stall=0, bubble loaded; with ID_EX_PERF_CNT_EN, o_flush_cnt increments by 1 and o_stall_cnt is unchanged.
- HALT valid in ID -> o_valid_EX=1 with halt; next 3 cycles bubbles; o_halted=1 and o_stall=1 on the 4th cycle and held until reset.
